param_data_buffer: RTL and testbench
====================================

Name: param_data_buffer

Overview:
Parametrised successor to the USB/AHB endpoint data buffer. It is a single shared circular byte FIFO between the AHB-lite slave side and the USB protocol side.
- AHB side: pushes and pops 1/2/4-byte little-endian words.
- USB side: pushes and pops single bytes.
- Adds over the previous generation: configurable depth and bus width, concurrent push+pop, full/empty/almost-full flags, and sticky overflow/underflow/size/collision errors.

Parameters:
DEPTH, 64, buffer size in bytes; power of two, >= 8.
BUS_BYTES, 4, AHB data width in bytes (1, 2 or 4).
ALMOST_FULL, DEPTH-BUS_BYTES, occupancy at or above which almost_full asserts.
(derived) OCC_W = $clog2(DEPTH)+1.

Ports:
clk  in  1  system clock; one clock domain; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
clear  in  1  flush buffer and errors.
store_tx_data  in  1  AHB push of data_size bytes from tx_data.
tx_data  in  8*BUS_BYTES  AHB write data, byte 0 = LSB, first into FIFO.
get_rx_data  in  1  AHB pop of data_size bytes into rx_data.
data_size  in  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3=reserved.
store_rx_packet_data  in  1  USB push of one byte.
rx_packet_data  in  8  USB byte in.
get_tx_packet_data  in  1  USB pop of one byte.
rx_data  out  8*BUS_BYTES  AHB read data, zero-extended above data_size.
tx_packet_data  out  8  USB byte out.
buffer_occupancy  out  OCC_W  bytes currently stored (0..DEPTH).
full, empty, almost_full  out  1 each  status flags.
overflow_err, underflow_err, size_err, collision_err  out  1 each  sticky error flags.

Behaviour:
- Reset (rst=1 at clk edge):
  - Pointers=0, occupancy=0.
  - rx_data=0, tx_packet_data=0, empty=1, full=0, almost_full=0.
  - All errors=0.
  - Storage contents are don't-care.
- clear: same effect as reset on all state, same cycle; dominates every other command.
- Push source arbitration, per cycle: store_tx_data beats store_rx_packet_data. If both are asserted, the USB push is dropped and collision_err is set.
- Pop source arbitration, per cycle: get_rx_data beats get_tx_packet_data. If both are asserted, the USB pop is dropped and collision_err is set.
- One push and one pop may occur in the same cycle.
- Byte counts:
  - AHB count = 1 << data_size.
  - data_size=3, or a count > BUS_BYTES → that AHB operation is a no-op and size_err is set.
- Pop check:
  - Pop is accepted only if pop count <= occupancy.
  - Otherwise no pop occurs, outputs hold, and underflow_err is set.
- Push check:
  - Push is accepted only if push count <= DEPTH - occupancy + accepted pop count.
  - Otherwise the entire push is rejected (no partial write) and overflow_err is set.
- Occupancy: next = occupancy + accepted push count − accepted pop count, registered.
- Flags are derived from the registered occupancy:
  - full = (occupancy == DEPTH).
  - empty = (occupancy == 0).
  - almost_full = (occupancy >= ALMOST_FULL).
- Read latency: rx_data and tx_packet_data are registered and update on the edge that accepts the pop. Data is valid from the following cycle and holds until the next accepted pop.
- Byte order: multi-byte pops place the oldest byte at [7:0]; unused upper lanes are 0.
- Wrap-around: pointers are modulo DEPTH. A multi-byte access straddling index DEPTH-1 → 0 splits correctly, with no gap and no stall.
- Read-during-write: a pop never returns bytes pushed in the same cycle, because the pop check uses pre-push occupancy.
- Error flags are sticky until clear or rst.

Decomposition:
- Package data_buffer_pkg:
  - enum size_t {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD}.
  - function size_to_bytes(size_t).
  - constant MAX_BUS_BYTES=4.
- Sub-module byte_ring_ram:
  - DEPTH×8 storage.
  - BUS_BYTES write lanes and BUS_BYTES read lanes, each addressed (base+i) mod DEPTH with a per-lane enable.
  - Synchronous write, combinational read.
- Top level holds arbitration, count and occupancy logic, and output registers.

Test Plan:
1. Reset; store_tx_data size=2, tx_data=0xDDCCBBAA; then 4 cycles of get_tx_packet_data → tx_packet_data AA,BB,CC,DD one cycle after each pop; occupancy 4,3,2,1,0; empty=1 at end.
2. USB pushes 0x11,0x22,0x33,0x44; get_rx_data size=1 → rx_data=0x00002211 next cycle. Then get_rx_data size=1 → rx_data=0x00004433; occupancy=0.
3. Sixteen word pushes → occupancy=64, full=1, almost_full=1 from occupancy 60. A 17th push of 0x12345678 → rejected, overflow_err=1, occupancy stays 64.
4. Wrap: push and pop 62 bytes; push word 0x04030201 (spans indices 62,63,0,1); get_rx_data size=2 → rx_data=0x04030201.
5. Occupancy=1; get_rx_data size=2 → rx_data unchanged, underflow_err=1, occupancy=1. Then data_size=3 push → size_err=1, occupancy unchanged.
6. Occupancy=61: store_tx_data word + get_tx_packet_data same cycle → both accepted, occupancy=64. Then store_tx_data + store_rx_packet_data together with clear=1 → occupancy=0, all errors=0, collision_err=0.

Source files
------------

// File: rtl/param_data_buffer_pkg.sv
// ---------------------------------------------------------------------------
// data_buffer_pkg
// Shared types and helpers for the parametrised endpoint data buffer.
//   size_t         : AHB transfer size encoding carried on data_size
//   size_to_bytes  : converts a size_t code into a byte count (0 = reserved)
//   MAX_BUS_BYTES  : widest AHB data path the buffer supports
// ---------------------------------------------------------------------------
package data_buffer_pkg;

    localparam int MAX_BUS_BYTES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_t;

    // The reserved code maps to zero bytes so callers can treat a zero
    // count as "illegal size".
    function automatic logic [2:0] size_to_bytes(size_t sz);
        logic [2:0] count;
        case (sz)
            SIZE_BYTE: count = 3'd1;
            SIZE_HALF: count = 3'd2;
            SIZE_WORD: count = 3'd4;
            default:   count = 3'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/param_data_buffer_if.sv
// ---------------------------------------------------------------------------
// param_data_buffer_if
// Bundles every command, data and status signal of the endpoint data buffer.
//   master modport : the side issuing pushes/pops (AHB slave logic, USB engine)
//   slave modport  : the buffer itself
// Commands : clear, store_tx_data, tx_data, get_rx_data, data_size,
//            store_rx_packet_data, rx_packet_data, get_tx_packet_data
// Results  : rx_data, tx_packet_data, buffer_occupancy, full, empty,
//            almost_full, overflow_err, underflow_err, size_err, collision_err
// ---------------------------------------------------------------------------
interface param_data_buffer_if #(
    parameter int DEPTH     = 64,
    parameter int BUS_BYTES = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                   clear;
    logic                   store_tx_data;
    logic [8*BUS_BYTES-1:0] tx_data;
    logic                   get_rx_data;
    logic [1:0]             data_size;
    logic                   store_rx_packet_data;
    logic [7:0]             rx_packet_data;
    logic                   get_tx_packet_data;

    logic [8*BUS_BYTES-1:0] rx_data;
    logic [7:0]             tx_packet_data;
    logic [OCC_W-1:0]       buffer_occupancy;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   overflow_err;
    logic                   underflow_err;
    logic                   size_err;
    logic                   collision_err;

    modport master (
        output clear, store_tx_data, tx_data, get_rx_data, data_size,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        input  rx_data, tx_packet_data, buffer_occupancy, full, empty,
               almost_full, overflow_err, underflow_err, size_err, collision_err
    );

    modport slave (
        input  clear, store_tx_data, tx_data, get_rx_data, data_size,
               store_rx_packet_data, rx_packet_data, get_tx_packet_data,
        output rx_data, tx_packet_data, buffer_occupancy, full, empty,
               almost_full, overflow_err, underflow_err, size_err, collision_err
    );

endinterface

// File: rtl/param_data_buffer_ram.sv
// ---------------------------------------------------------------------------
// byte_ring_ram
// DEPTH x 8 byte storage with LANES write lanes and LANES read lanes.
// Lane i addresses (base + i) mod DEPTH, so a multi-byte access that runs
// past the last index simply continues at index 0.
//   clk       : write clock
//   wrEn_i    : per-lane write enable
//   wrBase_i  : address of write lane 0
//   wrData_i  : write bytes, lane i in bits [8i+7:8i]
//   rdEn_i    : per-lane read enable; disabled lanes read as zero
//   rdBase_i  : address of read lane 0
//   rdData_o  : combinational read bytes, lane i in bits [8i+7:8i]
// ---------------------------------------------------------------------------
module byte_ring_ram #(
    parameter int DEPTH = 64,
    parameter int LANES = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic [LANES-1:0]   wrEn_i,
    input  logic [AW-1:0]      wrBase_i,
    input  logic [8*LANES-1:0] wrData_i,
    input  logic [LANES-1:0]   rdEn_i,
    input  logic [AW-1:0]      rdBase_i,
    output logic [8*LANES-1:0] rdData_o
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrAddr [LANES];
    logic [AW-1:0] rdAddr [LANES];

    // Lane addresses are kept AW bits wide so the addition wraps modulo
    // DEPTH on its own; DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wrAddr[i] = wrBase_i + AW'(i);
            rdAddr[i] = rdBase_i + AW'(i);
        end
    end

    // Storage write: every enabled lane lands in its own byte this edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wrEn_i[i]) begin
                mem[wrAddr[i]] <= wrData_i[8*i +: 8];
            end
        end
    end

    // Combinational read; lanes that are not enabled return zero so the
    // caller gets zero-extended data for short transfers for free.
    always_comb begin
        rdData_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rdEn_i[i]) begin
                rdData_o[8*i +: 8] = mem[rdAddr[i]];
            end
        end
    end

endmodule

// File: rtl/param_data_buffer.sv
// ---------------------------------------------------------------------------
// param_data_buffer
// Shared circular byte FIFO between the AHB-lite slave and the USB protocol
// engine. The AHB side moves 1/2/4-byte little-endian words, the USB side
// moves single bytes; one push and one pop may complete every cycle.
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : param_data_buffer_if.slave carrying commands, read data, status
//          flags (full/empty/almost_full, occupancy) and sticky error flags
// ---------------------------------------------------------------------------
module param_data_buffer
    import data_buffer_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int BUS_BYTES   = 4,
    parameter int ALMOST_FULL = DEPTH - BUS_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    param_data_buffer_if.slave    bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;
    // One extra bit so free space plus popped bytes never wraps.
    localparam int CW    = OCC_W + 1;
    localparam logic [2:0] BUS_BYTES_L = 3'(BUS_BYTES);

    logic [AW-1:0]          wrPtr_q, wrPtr_d;
    logic [AW-1:0]          rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [8*BUS_BYTES-1:0] rxData_q, rxData_d;
    logic [7:0]             txPkt_q, txPkt_d;
    logic                   overflowErr_q, overflowErr_d;
    logic                   underflowErr_q, underflowErr_d;
    logic                   sizeErr_q, sizeErr_d;
    logic                   collisionErr_q, collisionErr_d;

    logic [2:0]             ahbCount;
    logic                   ahbSizeOk;
    logic [CW-1:0]          popCount, popAccepted;
    logic [CW-1:0]          pushCount, pushAccepted;
    logic [CW-1:0]          room;
    logic                   popOk, pushOk;
    logic [BUS_BYTES-1:0]   wrEn, rdEn;
    logic [8*BUS_BYTES-1:0] wrData, rdData;

    byte_ring_ram #(
        .DEPTH (DEPTH),
        .LANES (BUS_BYTES)
    ) u_ram (
        .clk      (clk),
        .wrEn_i   (wrEn),
        .wrBase_i (wrPtr_q),
        .wrData_i (wrData),
        .rdEn_i   (rdEn),
        .rdBase_i (rdPtr_q),
        .rdData_o (rdData)
    );

    // Arbitration and acceptance. The pop is decided first against the
    // pre-push occupancy, so a pop can never see bytes written this cycle,
    // while the push may reuse the space that an accepted pop frees up.
    // A rejected or illegal-size request contributes a count of zero.
    always_comb begin
        ahbCount  = size_to_bytes(size_t'(bus.data_size));
        ahbSizeOk = (ahbCount != 3'd0) && (ahbCount <= BUS_BYTES_L);

        popCount = '0;
        if (bus.get_rx_data) begin
            popCount = ahbSizeOk ? CW'(ahbCount) : '0;
        end else if (bus.get_tx_packet_data) begin
            popCount = CW'(1);
        end
        popOk       = (popCount != '0) && (popCount <= CW'(occ_q));
        popAccepted = popOk ? popCount : '0;

        pushCount = '0;
        if (bus.store_tx_data) begin
            pushCount = ahbSizeOk ? CW'(ahbCount) : '0;
        end else if (bus.store_rx_packet_data) begin
            pushCount = CW'(1);
        end
        room         = CW'(DEPTH) - CW'(occ_q) + popAccepted;
        pushOk       = (pushCount != '0) && (pushCount <= room);
        pushAccepted = pushOk ? pushCount : '0;

        wrData = bus.tx_data;
        if (!bus.store_tx_data) begin
            wrData[7:0] = bus.rx_packet_data;
        end
        for (int i = 0; i < BUS_BYTES; i++) begin
            wrEn[i] = pushOk && (CW'(i) < pushCount);
            rdEn[i] = popOk && (CW'(i) < popCount);
        end
    end

    // Next-state for pointers, occupancy, read registers and sticky errors.
    // Read registers only move on an accepted pop of their own side, so a
    // failed pop leaves the last good data visible.
    always_comb begin
        wrPtr_d  = wrPtr_q + AW'(pushAccepted);
        rdPtr_d  = rdPtr_q + AW'(popAccepted);
        occ_d    = occ_q + OCC_W'(pushAccepted) - OCC_W'(popAccepted);
        rxData_d = rxData_q;
        txPkt_d  = txPkt_q;
        if (popOk && bus.get_rx_data) begin
            rxData_d = rdData;
        end
        if (popOk && !bus.get_rx_data) begin
            txPkt_d = rdData[7:0];
        end

        overflowErr_d  = overflowErr_q  | ((pushCount != '0) && !pushOk);
        underflowErr_d = underflowErr_q | ((popCount != '0) && !popOk);
        sizeErr_d      = sizeErr_q
                       | ((bus.store_tx_data || bus.get_rx_data) && !ahbSizeOk);
        collisionErr_d = collisionErr_q
                       | (bus.store_tx_data && bus.store_rx_packet_data)
                       | (bus.get_rx_data && bus.get_tx_packet_data);
    end

    // State registers. clear behaves exactly like reset and wins over any
    // command arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            wrPtr_q        <= '0;
            rdPtr_q        <= '0;
            occ_q          <= '0;
            rxData_q       <= '0;
            txPkt_q        <= '0;
            overflowErr_q  <= 1'b0;
            underflowErr_q <= 1'b0;
            sizeErr_q      <= 1'b0;
            collisionErr_q <= 1'b0;
        end else begin
            wrPtr_q        <= wrPtr_d;
            rdPtr_q        <= rdPtr_d;
            occ_q          <= occ_d;
            rxData_q       <= rxData_d;
            txPkt_q        <= txPkt_d;
            overflowErr_q  <= overflowErr_d;
            underflowErr_q <= underflowErr_d;
            sizeErr_q      <= sizeErr_d;
            collisionErr_q <= collisionErr_d;
        end
    end

    // Status flags follow the registered occupancy directly.
    always_comb begin
        bus.rx_data          = rxData_q;
        bus.tx_packet_data   = txPkt_q;
        bus.buffer_occupancy = occ_q;
        bus.full             = (occ_q == OCC_W'(DEPTH));
        bus.empty            = (occ_q == '0);
        bus.almost_full      = (occ_q >= OCC_W'(ALMOST_FULL));
        bus.overflow_err     = overflowErr_q;
        bus.underflow_err    = underflowErr_q;
        bus.size_err         = sizeErr_q;
        bus.collision_err    = collisionErr_q;
    end

endmodule

// File: tb/tb_param_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_param_data_buffer
// Directed bench for param_data_buffer (DEPTH=64, BUS_BYTES=4). A queue-based
// model of the byte FIFO predicts every output each cycle; literal
// expectations at key points pin the model to hand-worked values.
// ---------------------------------------------------------------------------
module tb_param_data_buffer;

    localparam int DEPTH       = 64;
    localparam int BUS_BYTES   = 4;
    localparam int ALMOST_FULL = DEPTH - BUS_BYTES;

    logic clk;
    logic rst;

    param_data_buffer_if #(.DEPTH(DEPTH), .BUS_BYTES(BUS_BYTES)) bus();

    param_data_buffer #(
        .DEPTH       (DEPTH),
        .BUS_BYTES   (BUS_BYTES),
        .ALMOST_FULL (ALMOST_FULL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0]  q[$];
    logic [31:0] mRx;
    logic [7:0]  mTx;
    bit          mOvf, mUdf, mSz, mCol;
    bit          modelStarted = 0;
    int          mN;
    bit          mOk;

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of commands, then returns every command to idle.
    task automatic applyStimulus(input logic storeTx, input logic [31:0] txData,
                                 input logic getRx, input logic [1:0] size,
                                 input logic storeRx, input logic [7:0] rxByte,
                                 input logic getTx, input logic clr);
        bus.store_tx_data        = storeTx;
        bus.tx_data              = txData;
        bus.get_rx_data          = getRx;
        bus.data_size            = size;
        bus.store_rx_packet_data = storeRx;
        bus.rx_packet_data       = rxByte;
        bus.get_tx_packet_data   = getTx;
        bus.clear                = clr;
        @(negedge clk);
        bus.store_tx_data        = 1'b0;
        bus.tx_data              = '0;
        bus.get_rx_data          = 1'b0;
        bus.data_size            = 2'd0;
        bus.store_rx_packet_data = 1'b0;
        bus.rx_packet_data       = '0;
        bus.get_tx_packet_data   = 1'b0;
        bus.clear                = 1'b0;
    endtask

    // Behavioural model: a byte queue. Pops are served from the queue as it
    // stood before this cycle's push; pushes need the whole count to fit.
    always @(posedge clk) begin
        modelStarted = 1;
        if (rst || bus.clear) begin
            q.delete();
            mRx = '0; mTx = '0;
            mOvf = 0; mUdf = 0; mSz = 0; mCol = 0;
        end else begin
            case (bus.data_size)
                2'd0:    mN = 1;
                2'd1:    mN = 2;
                2'd2:    mN = 4;
                default: mN = 0;
            endcase
            mOk = (mN != 0) && (mN <= BUS_BYTES);
            if (bus.get_rx_data) begin
                if (bus.get_tx_packet_data) mCol = 1;
                if (!mOk) mSz = 1;
                else if (mN > q.size()) mUdf = 1;
                else begin
                    mRx = '0;
                    for (int k = 0; k < mN; k++) mRx[8*k +: 8] = q.pop_front();
                end
            end else if (bus.get_tx_packet_data) begin
                if (q.size() == 0) mUdf = 1;
                else mTx = q.pop_front();
            end
            if (bus.store_tx_data) begin
                if (bus.store_rx_packet_data) mCol = 1;
                if (!mOk) mSz = 1;
                else if (mN > DEPTH - q.size()) mOvf = 1;
                else for (int k = 0; k < mN; k++) q.push_back(bus.tx_data[8*k +: 8]);
            end else if (bus.store_rx_packet_data) begin
                if (q.size() == DEPTH) mOvf = 1;
                else q.push_back(bus.rx_packet_data);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (modelStarted) begin
            checkOutput("model occupancy", 32'(bus.buffer_occupancy), 32'(q.size()));
            checkOutput("model full", 32'(bus.full), 32'(q.size() == DEPTH));
            checkOutput("model empty", 32'(bus.empty), 32'(q.size() == 0));
            checkOutput("model almost_full", 32'(bus.almost_full), 32'(q.size() >= ALMOST_FULL));
            checkOutput("model rx_data", bus.rx_data, mRx);
            checkOutput("model tx_packet_data", 32'(bus.tx_packet_data), 32'(mTx));
            checkOutput("model overflow_err", 32'(bus.overflow_err), 32'(mOvf));
            checkOutput("model underflow_err", 32'(bus.underflow_err), 32'(mUdf));
            checkOutput("model size_err", 32'(bus.size_err), 32'(mSz));
            checkOutput("model collision_err", 32'(bus.collision_err), 32'(mCol));
        end
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence with hand-computed literal expectations.
    initial begin
        logic [7:0] t1Bytes [4];
        t1Bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        rst = 1'b1;
        bus.store_tx_data = 0; bus.tx_data = '0; bus.get_rx_data = 0;
        bus.data_size = 0; bus.store_rx_packet_data = 0; bus.rx_packet_data = '0;
        bus.get_tx_packet_data = 0; bus.clear = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset occupancy", 32'(bus.buffer_occupancy), 32'd0);
        checkOutput("reset empty", 32'(bus.empty), 32'd1);
        checkOutput("reset full", 32'(bus.full), 32'd0);
        checkOutput("reset rx_data", bus.rx_data, 32'd0);
        checkOutput("reset errors", 32'({bus.overflow_err, bus.underflow_err,
                    bus.size_err, bus.collision_err}), 32'd0);

        // 1: AHB word in, USB bytes out
        applyStimulus(1, 32'hDDCCBBAA, 0, 2'd2, 0, 8'h00, 0, 0);
        checkOutput("t1 occupancy after push", 32'(bus.buffer_occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'd0, 0, 8'h00, 1, 0);
            checkOutput("t1 tx byte", 32'(bus.tx_packet_data), 32'(t1Bytes[i]));
            checkOutput("t1 occupancy", 32'(bus.buffer_occupancy), 32'(3 - i));
        end
        checkOutput("t1 empty", 32'(bus.empty), 32'd1);

        // 2: USB bytes in, AHB halfwords out
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h11, 0, 0);
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h22, 0, 0);
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h33, 0, 0);
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h44, 0, 0);
        applyStimulus(0, 0, 1, 2'd1, 0, 8'h00, 0, 0);
        checkOutput("t2 first half", bus.rx_data, 32'h00002211);
        applyStimulus(0, 0, 1, 2'd1, 0, 8'h00, 0, 0);
        checkOutput("t2 second half", bus.rx_data, 32'h00004433);
        checkOutput("t2 occupancy", 32'(bus.buffer_occupancy), 32'd0);

        // 3: fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 0, 2'd2, 0, 8'h00, 0, 0);
            if (i == 13) checkOutput("t3 almost_full at 56", 32'(bus.almost_full), 32'd0);
            if (i == 14) checkOutput("t3 almost_full at 60", 32'(bus.almost_full), 32'd1);
        end
        checkOutput("t3 occupancy full", 32'(bus.buffer_occupancy), 32'd64);
        checkOutput("t3 full", 32'(bus.full), 32'd1);
        applyStimulus(1, 32'h12345678, 0, 2'd2, 0, 8'h00, 0, 0);
        checkOutput("t3 overflow_err", 32'(bus.overflow_err), 32'd1);
        checkOutput("t3 occupancy held", 32'(bus.buffer_occupancy), 32'd64);
        applyStimulus(0, 0, 0, 2'd0, 0, 8'h00, 0, 1);
        checkOutput("t3 clear occupancy", 32'(bus.buffer_occupancy), 32'd0);

        // 4: advance pointers to 62, then a word straddling the wrap point
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h00, 0, 0);
        for (int i = 1; i < 62; i++) applyStimulus(0, 0, 0, 2'd0, 1, 8'(i), 1, 0);
        applyStimulus(0, 0, 0, 2'd0, 0, 8'h00, 1, 0);
        checkOutput("t4 occupancy before wrap", 32'(bus.buffer_occupancy), 32'd0);
        checkOutput("t4 last usb byte", 32'(bus.tx_packet_data), 32'd61);
        applyStimulus(1, 32'h04030201, 0, 2'd2, 0, 8'h00, 0, 0);
        checkOutput("t4 occupancy after wrap push", 32'(bus.buffer_occupancy), 32'd4);
        applyStimulus(0, 0, 1, 2'd2, 0, 8'h00, 0, 0);
        checkOutput("t4 wrapped word", bus.rx_data, 32'h04030201);
        checkOutput("t4 no underflow", 32'(bus.underflow_err), 32'd0);

        // 5: underflow and illegal size
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h5A, 0, 0);
        applyStimulus(0, 0, 1, 2'd2, 0, 8'h00, 0, 0);
        checkOutput("t5 rx_data held", bus.rx_data, 32'h04030201);
        checkOutput("t5 underflow_err", 32'(bus.underflow_err), 32'd1);
        checkOutput("t5 occupancy", 32'(bus.buffer_occupancy), 32'd1);
        applyStimulus(1, 32'hFFFFFFFF, 0, 2'd3, 0, 8'h00, 0, 0);
        checkOutput("t5 size_err", 32'(bus.size_err), 32'd1);
        checkOutput("t5 occupancy after bad size", 32'(bus.buffer_occupancy), 32'd1);

        // 6: concurrent push+pop at the edge of capacity, then clear wins
        applyStimulus(0, 0, 0, 2'd0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 15; i++) applyStimulus(1, 32'h10203040 ^ 32'(i), 0, 2'd2, 0, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 2'd0, 1, 8'hEE, 0, 0);
        checkOutput("t6 occupancy 61", 32'(bus.buffer_occupancy), 32'd61);
        applyStimulus(1, 32'hCAFEF00D, 0, 2'd2, 0, 8'h00, 1, 0);
        checkOutput("t6 occupancy 64", 32'(bus.buffer_occupancy), 32'd64);
        checkOutput("t6 popped byte", 32'(bus.tx_packet_data), 32'h40);
        checkOutput("t6 no overflow", 32'(bus.overflow_err), 32'd0);
        applyStimulus(1, 32'h11111111, 0, 2'd2, 1, 8'h22, 0, 1);
        checkOutput("t6 clear occupancy", 32'(bus.buffer_occupancy), 32'd0);
        checkOutput("t6 clear errors", 32'({bus.overflow_err, bus.underflow_err,
                    bus.size_err, bus.collision_err}), 32'd0);

        // 7: push and pop collisions, AHB side wins
        applyStimulus(1, 32'h00000077, 0, 2'd0, 1, 8'h99, 0, 0);
        checkOutput("t7 push collision occupancy", 32'(bus.buffer_occupancy), 32'd1);
        checkOutput("t7 collision_err", 32'(bus.collision_err), 32'd1);
        applyStimulus(0, 0, 0, 2'd0, 1, 8'h88, 0, 0);
        applyStimulus(0, 0, 1, 2'd0, 0, 8'h00, 1, 0);
        checkOutput("t7 ahb pop wins", bus.rx_data, 32'h00000077);
        checkOutput("t7 pop collision occupancy", 32'(bus.buffer_occupancy), 32'd1);
        applyStimulus(0, 0, 0, 2'd0, 0, 8'h00, 1, 0);
        checkOutput("t7 usb byte after collision", 32'(bus.tx_packet_data), 32'h88);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
